// File: rtl/fifo_aggregator_pkg.sv
// Shared defaults and helpers for the narrow-to-wide stream aggregator.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fifo_aggregator_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FETCH_WIDTH = 4;
    localparam int DEF_FIFO_DEPTH  = 3;

    // Low bit position of slot idx inside a packed vector of width-bit slots.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fifo_aggregator_fifo.sv
// First-word-fall-through FIFO, any depth >= 2 (pointers wrap modulo depth).
// Latency: a word written on edge t is visible on dout from cycle t+1.
// Backpressure: full_n=0 drops enq; deq while empty is ignored; clr/reset flush.
module fifo
    import fifo_aggregator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  enq,
    output logic                  full_n,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  deq,
    output logic                  empty_n,
    input  logic                  clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_enq;
    logic                  do_deq;

    assign full_n  = (cnt_q < CNT_W'(FIFO_DEPTH));
    assign empty_n = (cnt_q != '0);
    assign dout    = mem_q[rd_ptr_q];

    // Pointer/count next state; clr flushes and wins over both enq and deq.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        do_enq   = enq && full_n && !clr;
        do_deq   = deq && empty_n && !clr;
        if (do_enq) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_deq) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_enq, do_deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Control state registers; reset input is active-high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fifo_aggregator.sv
// Packs FETCH_WIDTH narrow words (first word in LSBs) into one wide word.
// Latency: FETCH_WIDTH+1 cycles from first enq to receiver_enq at full rate.
// Backpressure: receiver_full_n=0 holds the output word; the FIFO fills and full_n drops.
module fifo_aggregator
    import fifo_aggregator_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic                              enq,
    output logic                              full_n,
    input  logic                              clr,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq
);

    localparam int IDX_W = $clog2(FETCH_WIDTH);
    localparam int OUT_W = FETCH_WIDTH * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty_n;
    logic                  fifo_deq;
    logic                  flush;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ready_q, ready_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [OUT_W-1:0] out_q, out_d;

    fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .enq    (enq),
        .full_n (full_n),
        .dout   (fifo_dout),
        .deq    (fifo_deq),
        .empty_n(fifo_empty_n),
        .clr    (clr)
    );

    // Reset and clr must suppress a transfer in the same cycle, so gate the handshake.
    assign flush         = rst_n || clr;
    assign receiver_enq  = ready_q && receiver_full_n && !flush;
    assign fifo_deq      = fifo_empty_n && (!ready_q || receiver_enq) && !flush;
    assign receiver_data = out_q;

    // Packing: slots fill in pack_q; a completed group moves to out_q so the
    // next group can start while the previous one is still being offered.
    always_comb begin
        idx_d   = idx_q;
        ready_d = ready_q;
        pack_d  = pack_q;
        out_d   = out_q;
        if (receiver_enq) begin
            ready_d = 1'b0;
        end
        if (fifo_deq) begin
            pack_d[slice_lo(int'(idx_q), DATA_WIDTH) +: DATA_WIDTH] = fifo_dout;
            if (idx_q == IDX_W'(FETCH_WIDTH - 1)) begin
                idx_d   = '0;
                ready_d = 1'b1;
                out_d   = pack_d;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (clr) begin
            idx_d   = '0;
            ready_d = 1'b0;
            pack_d  = '0;
            out_d   = '0;
        end
    end

    // Aggregator state registers; reset input is active-high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
            pack_q  <= '0;
            out_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            ready_q <= ready_d;
            pack_q  <= pack_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fifo_aggregator.sv
// Scoreboard bench: accepted words are grouped in fours by a queue model;
// a negedge monitor pops and compares on every receiver_enq.
module tb_fifo_aggregator;

    localparam int DW = 16;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   din;
    logic            enq;
    logic            full_n;
    logic            clr;
    logic [FW*DW-1:0] receiver_data;
    logic            receiver_full_n;
    logic            receiver_enq;

    fifo_aggregator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din            (din),
        .enq            (enq),
        .full_n         (full_n),
        .clr            (clr),
        .receiver_data  (receiver_data),
        .receiver_full_n(receiver_full_n),
        .receiver_enq   (receiver_enq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [FW*DW-1:0] exp_q[$];
    logic [DW-1:0]    acc[$];
    int               xfer_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: every accepted word joins the open group; four make one output.
    task automatic push_word(input logic [DW-1:0] w);
        logic [FW*DW-1:0] g;
        acc.push_back(w);
        if (acc.size() == FW) begin
            g = '0;
            for (int k = 0; k < FW; k++) g[k*DW +: DW] = acc[k];
            exp_q.push_back(g);
            acc.delete();
        end
    endtask

    task automatic flush_model();
        acc.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic e, input logic [DW-1:0] d, input logic rfn, output logic accepted);
        @(posedge clk);
        #1;
        accepted = e && full_n;
        enq = e;
        din = d;
        receiver_full_n = rfn;
        if (accepted) push_word(d);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every transfer must match the oldest expected group.
    always @(negedge clk) begin
        if (receiver_enq === 1'b1) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got %h expected none", receiver_data);
            end else begin
                chk("transfer_data", receiver_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic a;
        logic e;
        logic r;
        int t0;
        logic [DW-1:0] ctr;

        rst_n = 1'b1;
        clr = 1'b0;
        enq = 1'b0;
        din = '0;
        receiver_full_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_full_n", 64'(full_n), 64'd1);
        chk("reset_receiver_enq", 64'(receiver_enq), 64'd0);
        chk("reset_receiver_data", receiver_data, 64'd0);

        // Full-rate stream 0..15: four groups, latency 5, cadence 4.
        xfer_cyc.delete();
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(i), 1'b1, a);
            if (i == 0) t0 = cyc;
            chk("stream_full_n", 64'(a), 64'd1);
        end
        drive(1'b0, '0, 1'b1, a);
        wait_drain(20);
        chk("stream_xfer_count", 64'(xfer_cyc.size()), 64'd4);
        if (xfer_cyc.size() == 4) begin
            chk("stream_latency", 64'(xfer_cyc[0] - t0), 64'd5);
            for (int k = 1; k < 4; k++)
                chk("stream_cadence", 64'(xfer_cyc[k] - xfer_cyc[k-1]), 64'd4);
        end

        // Backpressure: group 0..3 held, FIFO fills with 4,5,6, word 7 dropped.
        xfer_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i), 1'b0, a);
            chk("hold_full_n", 64'(a), (i <= 6) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, a);
            @(negedge clk);
            chk("hold_no_xfer", 64'(receiver_enq), 64'd0);
            chk("hold_data", receiver_data, 64'h0003_0002_0001_0000);
            chk("hold_full", 64'(full_n), 64'd0);
        end
        drive(1'b0, '0, 1'b1, a);
        wait_drain(10);
        drive(1'b1, 16'd8, 1'b1, a);
        drive(1'b0, '0, 1'b1, a);
        wait_drain(20);
        chk("hold_xfer_count", 64'(xfer_cyc.size()), 64'd2);
        chk("hold_full_n_after", 64'(full_n), 64'd1);

        // Reset mid-group: outputs back to reset values, partial group lost.
        drive(1'b1, 16'h00aa, 1'b1, a);
        drive(1'b1, 16'h00bb, 1'b1, a);
        @(posedge clk);
        #1;
        enq = 1'b0;
        rst_n = 1'b1;
        flush_model();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_receiver_enq", 64'(receiver_enq), 64'd0);
        chk("midrst_receiver_data", receiver_data, 64'd0);
        chk("midrst_full_n", 64'(full_n), 64'd1);
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h20 + i), 1'b1, a);
        drive(1'b0, '0, 1'b1, a);
        wait_drain(20);

        // clr after two words: nothing emitted, next four form a clean group.
        xfer_cyc.delete();
        drive(1'b1, 16'h0030, 1'b1, a);
        drive(1'b1, 16'h0031, 1'b1, a);
        @(posedge clk);
        #1;
        enq = 1'b0;
        clr = 1'b1;
        flush_model();
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_full_n", 64'(full_n), 64'd1);
        chk("clr_receiver_enq", 64'(receiver_enq), 64'd0);
        for (int i = 10; i < 14; i++) drive(1'b1, DW'(i), 1'b1, a);
        drive(1'b0, '0, 1'b1, a);
        wait_drain(20);
        chk("clr_xfer_count", 64'(xfer_cyc.size()), 64'd1);

        // Random enq stalls and receiver backpressure on a counting stream.
        ctr = 16'h0100;
        for (int i = 0; i < 2000; i++) begin
            e = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            drive(e, ctr, r, a);
            if (a) ctr = ctr + 1'b1;
        end
        drive(1'b0, '0, 1'b1, a);
        wait_drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_aggregator.md
# fifo_aggregator

Width-converting stream buffer: accepts DATA_WIDTH-bit words on a FIFO-style enqueue port, buffers them in an internal FIFO, and packs every FETCH_WIDTH consecutive words into one wide output word. The wide word is offered to a downstream receiver through an enq/full_n handshake. It sits between narrow producers, such as memory readers, and wide consumers, such as the patch/compute datapath.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per input word
- FETCH_WIDTH, 4, input words packed per output word (≥2)
- FIFO_DEPTH, 3, input FIFO entries (≥2); pointer/count widths derived with $clog2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-high (asserted when 1); name kept per codebase convention
- din  in  DATA_WIDTH  input word
- enq  in  1  write din this cycle; ignored when full_n=0
- full_n  out  1  FIFO can accept a word
- clr  in  1  synchronous flush of FIFO and aggregator state
- receiver_data  out  FETCH_WIDTH*DATA_WIDTH  packed word; word k of a group at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- receiver_full_n  in  1  receiver can accept this cycle
- receiver_enq  out  1  receiver_data is transferred this cycle

## Operation
- FIFO:
  - First-word-fall-through; dout = oldest entry whenever empty_n=1.
  - full_n = (count < FIFO_DEPTH); empty_n = (count > 0).
  - enq with full_n=0 is dropped; deq with empty_n=0 is ignored.
  - Simultaneous enq and deq when non-empty and non-full: count unchanged, both occur.
  - Pointers wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two.
- Aggregator:
  - Holds idx (0..FETCH_WIDTH-1), a packing register, and a flag `ready`.
  - deq = empty_n && (!ready || receiver_enq).
  - On deq, dout is written into slot idx and idx increments.
  - When slot FETCH_WIDTH-1 is written, idx returns to 0 and ready is set.
  - receiver_enq = ready && receiver_full_n (combinational).
  - On receiver_enq, ready clears unless a new group completes in the same cycle, which is only possible for FETCH_WIDTH=1 and is not supported.
  - A deq in the same cycle as receiver_enq writes slot 0 of the next group; the packing register for the emitted group is kept separate until transfer (double-register or output register).
- Order is preserved: the first word enqueued in a group lands in the LSBs.
- Reset or clr: FIFO empty, idx=0, ready=0. Reset values: full_n=1, receiver_enq=0, receiver_data=0. Partial groups are discarded.

## Timing
- Word enqueued at edge t is visible on dout and dequeueable from cycle t+1.
- Group completes on the edge that dequeues word FETCH_WIDTH-1. receiver_enq may assert in the following cycle.
- Minimum latency from the first enq of a group to receiver_enq is FETCH_WIDTH+1 cycles at one word per cycle.
- Sustained throughput: one input word per cycle; one output per FETCH_WIDTH cycles.
- receiver_full_n=0 holds ready and receiver_data stable. The FIFO then fills and full_n drops after FIFO_DEPTH more enqueues.
- Reset or clr dominates enq, deq and transfer in the same cycle.

## Structure
- Sub-module `fifo`: DATA_WIDTH, FIFO_DEPTH; ports clk, rst_n, din, enq, full_n, dout, deq, empty_n, clr.
- Aggregator logic lives in the top module.
- Shared package: default DATA_WIDTH/FETCH_WIDTH constants and a packed-slice index function.

## Test plan
- Reset, then enq 0,1,2,…,15 on consecutive cycles with receiver_full_n=1 → four transfers: {3,2,1,0}, {7,6,5,4}, {11,10,9,8}, {15,14,13,12} (LSB word first), with no gaps beyond the FETCH_WIDTH cadence.
- Random enq stalls (50%) on an incrementing counter for 2000 cycles → each transfer's word k equals base+k, and base advances by 4 per transfer.
- Hold receiver_full_n=0 after the first group completes → receiver_enq=0 and data stable. full_n falls after 3 further enqueues. Release → transfer, and the FIFO drains in order.
- Enq 2 words, then assert clr → full_n=1, no transfer. The next 4 words 10,11,12,13 produce {13,12,11,10}.
- Assert rst_n mid-group → outputs return to reset values the next cycle, and the partial group is discarded.
- Enq while full_n=0 → word dropped; the output sequence skips it with no corruption.
